// File: rtl/sevenseg_scan_display.sv
// -----------------------------------------------------------------------------
// sevenseg_scan_display
//
// Multi-digit, time-multiplexed 7-segment driver for the R15 register view.
// A load strobe snapshots `value` and renders it into a digit buffer either
// directly as hex nibbles or, in decimal mode, through an iterative
// double-dabble converter (one shift step per clock, DATA_W steps). The
// buffer is only written as a whole, so a partial BCD result is never shown.
// A free-running prescaler steps the lit digit every REFRESH_DIV clocks.
//
// Parameters
//   DATA_W      width of the displayed value (4..16)
//   NUM_DIGITS  number of physical common-anode digits (1..8)
//   REFRESH_DIV clocks each digit stays lit (>= 2)
//
// Ports
//   clk       system clock, rising edge
//   rst_n     synchronous active-low reset
//   value     value to display, sampled on load
//   load      one-cycle snapshot strobe, ignored while busy
//   dec_mode  sampled with load: 0 = hex, 1 = unsigned decimal
//   busy      decimal conversion in progress
//   ovf       nonzero digit(s) exist above NUM_DIGITS and were truncated
//   seg       {g,f,e,d,c,b,a}, active-low, registered
//   an        digit enables, active-low one-hot, registered
//
// Optional feature
//   SEVENSEG_LZB_EN  when defined, digits above the most significant nonzero
//                    digit are blanked (seg = 7'h7F) while still strobed.
//                    Digit 0 is never blanked. The mask is captured at commit.
// -----------------------------------------------------------------------------
module sevenseg_scan_display #(
    parameter int DATA_W      = 8,
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_W-1:0]     value,
    input  logic                  load,
    input  logic                  dec_mode,
    output logic                  busy,
    output logic                  ovf,
    output logic [6:0]            seg,
    output logic [NUM_DIGITS-1:0] an
);

    localparam int BCD_DIGITS = (DATA_W + 2) / 3 + 1;
    localparam int BCD_W      = 4 * BCD_DIGITS;
    localparam int BUF_W      = 4 * NUM_DIGITS;
    localparam int HEX_EXT_W  = BUF_W + DATA_W;
    localparam int BCD_EXT_W  = BUF_W + BCD_W;
    localparam int CNT_W      = $clog2(DATA_W);
    localparam int PRE_W      = $clog2(REFRESH_DIV);
    localparam int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W - 1);
    localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

    typedef enum logic {
        IDLE,
        CONV
    } state_t;

    state_t state;
    state_t state_next;

    // Display buffer and blanking mask
    logic [NUM_DIGITS-1:0][3:0] digit_buf;
    logic [NUM_DIGITS-1:0]      blank_mask;

    // Double-dabble datapath
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] shreg_next;
    logic [BCD_W-1:0]  bcd;
    logic [BCD_W-1:0]  bcd_adj;
    logic [BCD_W-1:0]  bcd_next;
    logic [CNT_W-1:0]  step;

    // Scan
    logic [PRE_W-1:0] prescale;
    logic [IDX_W-1:0] scan_idx;

    // Commit path
    logic [HEX_EXT_W-1:0] value_ext;
    logic [BCD_EXT_W-1:0] bcd_ext;
    logic [BUF_W-1:0]     hex_digits;
    logic [BUF_W-1:0]     dec_digits;
    logic [BUF_W-1:0]     commit_digits;
    logic                 hex_ovf;
    logic                 dec_ovf;
    logic                 commit_ovf;
    logic                 commit_en;
    logic                 start_conv;
    logic                 last_step;

    // -------------------------------------------------------------------------
    // Segment decode, active-low {g,f,e,d,c,b,a}
    // -------------------------------------------------------------------------
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        unique case (d)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            4'hF: s = 7'h0E;
        endcase
        return s;
    endfunction

    // -------------------------------------------------------------------------
    // Hex rendering: zero-extend so nibbles past DATA_W read as 0 and any bits
    // above the displayed digits land in the overflow reduction.
    // -------------------------------------------------------------------------
    always_comb begin
        value_ext  = HEX_EXT_W'(value);
        hex_digits = value_ext[BUF_W-1:0];
        hex_ovf    = |(value_ext >> BUF_W);
    end

    // -------------------------------------------------------------------------
    // One double-dabble step: add 3 to every BCD nibble >= 5, then shift the
    // {bcd, shreg} pair left by one.
    // -------------------------------------------------------------------------
    always_comb begin
        bcd_adj = bcd;
        for (int unsigned i = 0; i < BCD_DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
        {bcd_next, shreg_next} = {bcd_adj, shreg} << 1;
    end

    // Decimal commit uses the result of the step being taken this cycle.
    always_comb begin
        bcd_ext    = BCD_EXT_W'(bcd_next);
        dec_digits = bcd_ext[BUF_W-1:0];
        dec_ovf    = |(bcd_ext >> BUF_W);
    end

    always_comb begin
        start_conv    = (state == IDLE) && load && dec_mode;
        last_step     = (state == CONV) && (step == LAST_STEP);
        commit_en     = ((state == IDLE) && load && !dec_mode) || last_step;
        commit_digits = last_step ? dec_digits : hex_digits;
        commit_ovf    = last_step ? dec_ovf : hex_ovf;
    end

    // -------------------------------------------------------------------------
    // FSM: state register / next state / outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (load && dec_mode) state_next = CONV;
            CONV: if (step == LAST_STEP) state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == CONV);
    end

    // -------------------------------------------------------------------------
    // Conversion registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shreg <= '0;
            bcd   <= '0;
            step  <= '0;
        end else if (start_conv) begin
            shreg <= value;
            bcd   <= '0;
            step  <= '0;
        end else if (state == CONV) begin
            shreg <= shreg_next;
            bcd   <= bcd_next;
            step  <= step + CNT_W'(1);
        end
    end

    // -------------------------------------------------------------------------
    // Digit buffer and overflow flag, written only as a complete result
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            digit_buf <= '0;
            ovf       <= 1'b0;
        end else if (commit_en) begin
            digit_buf <= commit_digits;
            ovf       <= commit_ovf;
        end
    end

`ifdef SEVENSEG_LZB_EN
    // Marks every digit whose own value and all digits above it are zero.
    // Digit 0 is excluded so a zero value still shows "0".
    function automatic logic [NUM_DIGITS-1:0] lead_zero_mask(
        input logic [NUM_DIGITS-1:0][3:0] d
    );
        logic [NUM_DIGITS-1:0] m;
        logic                  zero_above;
        int unsigned           i;
        m          = '0;
        zero_above = 1'b1;
        for (int unsigned k = 1; k < NUM_DIGITS; k++) begin
            i          = NUM_DIGITS - k;
            zero_above = zero_above & (d[i] == 4'd0);
            m[i]       = zero_above;
        end
        return m;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            blank_mask <= '0;
        end else if (commit_en) begin
            blank_mask <= lead_zero_mask(commit_digits);
        end
    end
`else
    always_comb begin
        blank_mask = '0;
    end
`endif

    // -------------------------------------------------------------------------
    // Refresh prescaler and scan index
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prescale <= '0;
            scan_idx <= '0;
        end else if (prescale == PRE_LAST) begin
            prescale <= '0;
            scan_idx <= (scan_idx == IDX_LAST) ? '0 : scan_idx + IDX_W'(1);
        end else begin
            prescale <= prescale + PRE_W'(1);
        end
    end

    // -------------------------------------------------------------------------
    // Registered pin outputs, one cycle behind scan index and buffer
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seg <= 7'h7F;
            an  <= '1;
        end else begin
            an  <= ~(NUM_DIGITS'(1) << scan_idx);
            seg <= blank_mask[scan_idx] ? 7'h7F : seg_decode(digit_buf[scan_idx]);
        end
    end

endmodule
